// File: rtl/nonce_search_if.sv
// nonce_search_if: host/config and hash-core signals of the nonce search sequencer.
interface nonce_search_if #(parameter int CNT_W = 32);
    logic             start;
    logic             abort;
    logic [255:0]     base_nonce;
    logic [255:0]     target;
    logic [CNT_W-1:0] max_attempts;
    logic [255:0]     nonce_out;
    logic [255:0]     hash_in;
    logic             busy;
    logic             done;
    logic             found;
    logic [255:0]     found_nonce;
    logic [255:0]     found_hash;
    logic [CNT_W-1:0] attempts;
    modport slave (
        input  start, abort, base_nonce, target, max_attempts, hash_in,
        output nonce_out, busy, done, found, found_nonce, found_hash, attempts
    );
    modport master (
        output start, abort, base_nonce, target, max_attempts, hash_in,
        input  nonce_out, busy, done, found, found_nonce, found_hash, attempts
    );
endinterface

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: walks nonce word 7 through the hash core until a digest falls
// strictly below target, the attempt budget runs out, or the host aborts.
module nonce_search_ctrl #(
    parameter int HASH_LATENCY = 0,
    parameter int CNT_W        = 32
) (
    input logic           clk,
    input logic           rst,
    nonce_search_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
    localparam int WW = (HASH_LATENCY > 1) ? $clog2(HASH_LATENCY) : 1;
    // WAIT holds HASH_LATENCY cycles and CHECK one more, so an attempt takes HASH_LATENCY+1
    localparam logic [WW-1:0] RELOAD = WW'((HASH_LATENCY > 0) ? HASH_LATENCY - 1 : 0);
    localparam state_t FIRST = (HASH_LATENCY == 0) ? CHECK : WAIT;
    state_t           r_state, w_next;
    logic [WW-1:0]    r_wait;
    logic [255:0]     r_nonce, r_target, r_found_nonce, r_found_hash;
    logic [CNT_W-1:0] r_max, r_attempts, w_attempts_inc;
    logic             r_found, w_accept, w_check, w_hit, w_last;
    assign w_accept       = (r_state == IDLE) && bus.start;
    assign w_check        = (r_state == CHECK) && !bus.abort;
    assign w_hit          = bus.hash_in < r_target;
    assign w_attempts_inc = r_attempts + CNT_W'(1);
    assign w_last         = (r_max != '0) && (w_attempts_inc == r_max);
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = bus.start ? FIRST : IDLE;
            WAIT:    w_next = bus.abort ? IDLE : (r_wait == '0) ? CHECK : WAIT;
            CHECK:   w_next = bus.abort ? IDLE : (w_hit || w_last) ? DONE : FIRST;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        bus.busy        = r_state != IDLE;
        bus.done        = r_state == DONE;
        bus.found       = r_found;
        bus.nonce_out   = r_nonce;
        bus.found_nonce = r_found_nonce;
        bus.found_hash  = r_found_hash;
        bus.attempts    = r_attempts;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait        <= '0;
            r_nonce       <= '0;
            r_target      <= '0;
            r_max         <= '0;
            r_attempts    <= '0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
        end else begin
            if (w_accept) begin
                r_nonce    <= bus.base_nonce;
                r_target   <= bus.target;
                r_max      <= bus.max_attempts;
                r_attempts <= '0;
                r_found    <= 1'b0;
                r_wait     <= RELOAD;
            end
            if (r_state == WAIT) r_wait <= r_wait - WW'(1);
            if (w_check) begin
                r_attempts <= w_attempts_inc;
                if (w_hit) begin
                    r_found       <= 1'b1;
                    r_found_nonce <= r_nonce;
                    r_found_hash  <= bus.hash_in;
                end else if (!w_last) begin
                    r_nonce[31:0] <= r_nonce[31:0] + 32'd1;
                    r_wait        <= RELOAD;
                end
            end
        end
    end
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// tb_nonce_search_ctrl: directed searches on a zero-latency and a two-cycle-latency core,
// checked by per-instance scoreboards that pop on every done pulse.
module tb_nonce_search_ctrl;
    typedef struct {
        logic         found;
        logic [255:0] fn;
        logic [255:0] fh;
        logic [255:0] nout;
        logic [31:0]  att;
        int           sc;
        int           dl;
    } exp_t;
    localparam logic [255:0] ONES = '1;
    localparam logic [255:0] B    = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4_10000000;
    localparam logic [255:0] W    = 256'hdeadbeef_cafef00d_11223344_55667788_99aabbcc_ddeeff00_a5a5a5a5_fffffffe;
    localparam logic [255:0] T    = {32'h0000ffff, 192'h0, 32'h00000100};
    logic clk = 1'b0, rst = 1'b1;
    int   cyc = 0, n_chk = 0, n_fail = 0, m0 = 2, m2 = 0;
    exp_t q0[$], q2[$], e0, e2;
    logic [255:0] p1, p2;
    nonce_search_if #(.CNT_W(32)) b0 ();
    nonce_search_if #(.CNT_W(32)) b2 ();
    nonce_search_ctrl #(.HASH_LATENCY(0), .CNT_W(32)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    nonce_search_ctrl #(.HASH_LATENCY(2), .CNT_W(32)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Stub core: mode 2 echoes the nonce, mode 1 gives target at offset 2 and target-1 at offset 3
    function automatic logic [255:0] stub(int m, logic [255:0] n, logic [31:0] b7, logic [255:0] t);
        logic [31:0] off;
        off = n[31:0] - b7;
        return (m == 2) ? n : (m == 1) ? ((off == 2) ? t : (off == 3) ? t - 1 : ONES) : ONES;
    endfunction
    assign b0.hash_in = stub(m0, b0.nonce_out, b0.base_nonce[31:0], b0.target);
    always @(posedge clk) begin
        p1 <= stub(m2, b2.nonce_out, b2.base_nonce[31:0], b2.target);
        p2 <= p1;
    end
    assign b2.hash_in = p2;
    function automatic void chk(string nm, logic [255:0] a, logic [255:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endfunction
    function automatic void cmp_done(string d, exp_t e, logic f, logic [255:0] fn, logic [255:0] fh,
                                     logic [255:0] nout, logic [31:0] att, int c);
        chk({d, " found"}, 256'(f), 256'(e.found));
        chk({d, " found_nonce"}, fn, e.fn);
        chk({d, " found_hash"}, fh, e.fh);
        chk({d, " nonce_out"}, nout, e.nout);
        chk({d, " attempts"}, 256'(att), 256'(e.att));
        chk({d, " done cycle"}, 256'(c - e.sc), 256'(e.dl));
    endfunction
    always @(negedge clk) if (b0.done) begin
        if (q0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL dut0 done: pulse with no pending search");
        end else begin
            e0 = q0.pop_front();
            cmp_done("dut0", e0, b0.found, b0.found_nonce, b0.found_hash, b0.nonce_out, b0.attempts, cyc);
        end
    end
    always @(negedge clk) if (b2.done) begin
        if (q2.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL dut2 done: pulse with no pending search");
        end else begin
            e2 = q2.pop_front();
            cmp_done("dut2", e2, b2.found, b2.found_nonce, b2.found_hash, b2.nonce_out, b2.attempts, cyc);
        end
    end
    task automatic wait_idle(input bit d2);
        for (int i = 0; i < 300; i++) begin
            if (!(d2 ? b2.busy : b0.busy)) return;
            @(negedge clk);
        end
        n_chk++; n_fail++;
        $display("FAIL busy timeout: dut%0d still busy after 300 cycles", d2 ? 2 : 0);
    endtask
    task automatic run(input bit d2, input logic [255:0] base, input logic [255:0] tgt,
                       input logic [31:0] mx, input exp_t e);
        @(negedge clk);
        e.sc = cyc;
        if (d2) begin
            b2.base_nonce = base; b2.target = tgt; b2.max_attempts = mx; b2.start = 1'b1;
            q2.push_back(e);
        end else begin
            b0.base_nonce = base; b0.target = tgt; b0.max_attempts = mx; b0.start = 1'b1;
            q0.push_back(e);
        end
        @(negedge clk);
        b0.start = 1'b0; b2.start = 1'b0;
        wait_idle(d2);
    endtask
    task automatic chk_reset(string d, logic bs, logic dn, logic f, logic [255:0] n,
                             logic [255:0] fn, logic [255:0] fh, logic [31:0] att);
        chk({d, " reset busy"}, 256'(bs), 256'(0));
        chk({d, " reset done"}, 256'(dn), 256'(0));
        chk({d, " reset found"}, 256'(f), 256'(0));
        chk({d, " reset nonce_out"}, n, 256'(0));
        chk({d, " reset found_nonce"}, fn, 256'(0));
        chk({d, " reset found_hash"}, fh, 256'(0));
        chk({d, " reset attempts"}, 256'(att), 256'(0));
    endtask
    initial begin
        b0.start = 0; b0.abort = 0; b0.base_nonce = '0; b0.target = '0; b0.max_attempts = '0;
        b2.start = 0; b2.abort = 0; b2.base_nonce = '0; b2.target = '0; b2.max_attempts = '0;
        repeat (3) @(negedge clk);
        chk_reset("dut0", b0.busy, b0.done, b0.found, b0.nonce_out, b0.found_nonce, b0.found_hash, b0.attempts);
        chk_reset("dut2", b2.busy, b2.done, b2.found, b2.nonce_out, b2.found_nonce, b2.found_hash, b2.attempts);
        rst = 1'b0;
        run(0, 256'h1, ONES, 0, '{found:1'b1, fn:256'h1, fh:256'h1, nout:256'h1, att:1, sc:0, dl:2});
        run(1, B, 256'h0, 5, '{found:1'b0, fn:256'h0, fh:256'h0, nout:{B[255:32], 32'h10000004},
                              att:5, sc:0, dl:16});
        run(1, W, 256'h0, 3, '{found:1'b0, fn:256'h0, fh:256'h0, nout:{W[255:32], 32'h00000000},
                              att:3, sc:0, dl:10});
        m2 = 1;
        run(1, B, T, 0, '{found:1'b1, fn:{B[255:32], 32'h10000003}, fh:{32'h0000ffff, 192'h0, 32'h000000ff},
                           nout:{B[255:32], 32'h10000003}, att:4, sc:0, dl:13});
        m2 = 0;
        @(negedge clk);
        b2.base_nonce = B; b2.target = '0; b2.max_attempts = '0; b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        repeat (7) @(negedge clk);
        b2.abort = 1'b1;
        @(negedge clk);
        b2.abort = 1'b0;
        chk("abort busy", 256'(b2.busy), 256'(0));
        chk("abort found", 256'(b2.found), 256'(0));
        chk("abort attempts", 256'(b2.attempts), 256'(2));
        chk("abort nonce_out", b2.nonce_out, {B[255:32], 32'h10000002});
        chk("abort found_nonce held", b2.found_nonce, {B[255:32], 32'h10000003});
        repeat (3) @(negedge clk);
        m2 = 2;
        run(1, B, ONES, 0, '{found:1'b1, fn:B, fh:B, nout:B, att:1, sc:0, dl:4});
        m2 = 0;
        @(negedge clk);
        b2.base_nonce = B; b2.target = '0; b2.max_attempts = '0; b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        repeat (3) @(negedge clk);
        b2.base_nonce = W; b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        chk("busy start nonce_out", b2.nonce_out, {B[255:32], 32'h10000001});
        chk("busy start attempts", 256'(b2.attempts), 256'(1));
        chk("busy start busy", 256'(b2.busy), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("mid-wait", b2.busy, b2.done, b2.found, b2.nonce_out, b2.found_nonce, b2.found_hash, b2.attempts);
        repeat (4) @(negedge clk);
        chk("dut0 scoreboard drained", 256'(q0.size()), 256'(0));
        chk("dut2 scoreboard drained", 256'(q2.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
